sar_out_buffer: RTL and testbench

- Parametrised successor to the SAR output latch: captures each finished conversion word on the rising edge of FINAL, optionally averages 2^k conversions, and queues results in a FIFO.
- Results are drained through a valid/ready interface.
- Sits between the SAR control logic (FINAL, SWP) and the digital readout (scan chain / SPI / TT output pins).
- Adds overflow detection and a fill-level indicator.

---
 rtl/sar_pkg.sv | 11 +
 rtl/sar_sync_fifo.sv | 54 +++++
 rtl/sar_out_buffer.sv | 70 +++++++
 tb/tb_sar_out_buffer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared constants and width helper for the SAR output buffer.
package sar_pkg;
  localparam int SAR_WIDTH = 8;
  localparam int SAR_MAX_AVG_LOG2 = 3;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/sar_sync_fifo.sv
// sar_sync_fifo: synchronous FIFO with registered head word, valid and level.
module sar_sync_fifo import sar_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   valid_o,
  output logic                   drop_o,
  output logic [clog2(DEPTH):0]  level_o
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic valid_q, valid_d, full, pop, wr;
  assign full = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign pop = pop_i & valid_q;
  assign wr = push_i & (~full | pop);
  assign drop_o = push_i & ~wr;
  always_comb begin
    wptr_d = wptr_q + (AW+1)'(wr);
    rptr_d = rptr_q + (AW+1)'(pop);
    level_d = level_q + (AW+1)'(wr) - (AW+1)'(pop);
    valid_d = level_d != '0;
    // The head after this edge is either the word being written now or already in memory
    dout_d = (level_q == (AW+1)'(pop)) ? (wr ? wdata_i : dout_q) : mem_q[rptr_d[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
    end
  end
  assign rdata_o = dout_q;
  assign valid_o = valid_q;
  assign level_o = level_q;
endmodule

// File: rtl/sar_out_buffer.sv
// sar_out_buffer: synchronises FINAL, averages 2^k conversions and queues results.
module sar_out_buffer import sar_pkg::*; #(
  parameter int WIDTH = SAR_WIDTH,
  parameter int DEPTH = 4,
  parameter int MAX_AVG_LOG2 = SAR_MAX_AVG_LOG2
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                EN,
  input  logic                                FINAL,
  input  logic [WIDTH-1:0]                    SWP,
  input  logic [clog2(MAX_AVG_LOG2+1)-1:0]    AVG_SEL,
  output logic [WIDTH-1:0]                    DOUT,
  output logic                                DVALID,
  input  logic                                DREADY,
  output logic                                OVF,
  output logic [clog2(DEPTH):0]               LEVEL
);
  localparam int KW = clog2(MAX_AVG_LOG2 + 1);
  localparam int AW = WIDTH + MAX_AVG_LOG2;
  localparam int CW = MAX_AVG_LOG2 + 1;
  logic clr, cap, push, drop, ovf_q, ovf_d;
  logic [2:0] sync_q, sync_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  logic [KW-1:0] k_q, k_d, k_sel;
  logic [WIDTH-1:0] avg;
  assign clr = RST | ~EN;
  always_comb begin
    // sync_q[1:0] is the 2-FF synchroniser, sync_q[2] the edge-detect history
    sync_d = {sync_q[1:0], FINAL};
    cap = sync_q[1] & ~sync_q[2];
    k_sel = (AVG_SEL > KW'(MAX_AVG_LOG2)) ? KW'(MAX_AVG_LOG2) : AVG_SEL;
    k_d = (cap && cnt_q == '0) ? k_sel : k_q;
    sum = acc_q + AW'(SWP);
    cnt_n = cnt_q + CW'(1);
    push = cap && cnt_n == (CW'(1) << k_d);
    avg = WIDTH'(sum >> k_d);
    acc_d = push ? '0 : cap ? sum : acc_q;
    cnt_d = push ? '0 : cap ? cnt_n : cnt_q;
    ovf_d = ovf_q | drop;
  end
  always_ff @(posedge CLK) begin
    if (clr) begin
      sync_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      ovf_q <= ovf_d;
    end
  end
  sar_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK),
    .rst(clr),
    .push_i(push),
    .wdata_i(avg),
    .pop_i(DREADY),
    .rdata_o(DOUT),
    .valid_o(DVALID),
    .drop_o(drop),
    .level_o(LEVEL)
  );
  assign OVF = ovf_q;
endmodule

// File: tb/tb_sar_out_buffer.sv
// tb_sar_out_buffer: directed checks of capture latency, averaging, overflow and clear.
module tb_sar_out_buffer;
  logic CLK = 1'b0, RST, EN, FINAL, DREADY, DVALID, OVF;
  logic [7:0] SWP, DOUT;
  logic [1:0] AVG_SEL;
  logic [2:0] LEVEL;
  int errors = 0, checks = 0;
  sar_out_buffer dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FINAL(FINAL), .SWP(SWP), .AVG_SEL(AVG_SEL),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .OVF(OVF), .LEVEL(LEVEL)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic conv(input logic [7:0] v);
    SWP = v;
    FINAL = 1'b1;
    repeat (3) tick();
    FINAL = 1'b0;
    repeat (3) tick();
  endtask
  // Pop exactly on the edge where this conversion is pushed
  task automatic conv_pop(input logic [7:0] v, input logic [7:0] head);
    SWP = v;
    FINAL = 1'b1;
    repeat (2) tick();
    chk("cp_valid", DVALID, 1);
    chk("cp_head", DOUT, head);
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
    FINAL = 1'b0;
    repeat (3) tick();
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, DVALID, 1);
    chk({tag, "_dout"}, DOUT, exp);
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
  endtask
  initial begin
    RST = 1'b1; EN = 1'b0; FINAL = 1'b0; SWP = '0; AVG_SEL = '0; DREADY = 1'b0;
    repeat (3) tick();
    RST = 1'b0; EN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", DVALID, 0);
      chk("idle_dout", DOUT, 8'h00);
      chk("idle_level", LEVEL, 0);
      chk("idle_ovf", OVF, 0);
    end
    SWP = 8'hA5; FINAL = 1'b1;
    tick(); chk("lat1_valid", DVALID, 0);
    tick(); chk("lat2_valid", DVALID, 0);
    tick(); chk("lat3_valid", DVALID, 1);
    chk("single_dout", DOUT, 8'hA5);
    chk("single_level", LEVEL, 1);
    FINAL = 1'b0;
    repeat (3) tick();
    pop_chk("single_pop", 8'hA5);
    chk("single_empty", DVALID, 0);
    chk("single_lvl0", LEVEL, 0);
    chk("single_hold", DOUT, 8'hA5);
    AVG_SEL = 2'd2;
    conv(8'h10);
    conv(8'h20);
    AVG_SEL = 2'd0;
    conv(8'h30);
    chk("avg3_valid", DVALID, 0);
    chk("avg3_level", LEVEL, 0);
    conv(8'h41);
    chk("avg4_level", LEVEL, 1);
    pop_chk("avg4", 8'h28);
    chk("avg4_empty", LEVEL, 0);
    for (int i = 1; i <= 4; i++) conv(8'(i));
    chk("fill_level", LEVEL, 4);
    chk("fill_ovf", OVF, 0);
    conv(8'h05);
    chk("ovf5_level", LEVEL, 4);
    chk("ovf5_ovf", OVF, 1);
    conv(8'h06);
    chk("ovf6_level", LEVEL, 4);
    for (int i = 1; i <= 4; i++) pop_chk("ovf_pop", 8'(i));
    chk("ovf_drained", DVALID, 0);
    chk("ovf_sticky", OVF, 1);
    EN = 1'b0;
    tick();
    EN = 1'b1;
    chk("en_ovf", OVF, 0);
    chk("en_level", LEVEL, 0);
    chk("en_dout", DOUT, 8'h00);
    for (int i = 1; i <= 4; i++) conv(8'(i));
    conv_pop(8'h07, 8'h01);
    chk("pp1_level", LEVEL, 4);
    chk("pp1_ovf", OVF, 0);
    conv_pop(8'h08, 8'h02);
    chk("pp2_level", LEVEL, 4);
    chk("pp2_ovf", OVF, 0);
    pop_chk("pp_pop3", 8'h03);
    pop_chk("pp_pop4", 8'h04);
    pop_chk("pp_pop7", 8'h07);
    pop_chk("pp_pop8", 8'h08);
    chk("pp_empty", DVALID, 0);
    chk("pp_ovf_end", OVF, 0);
    AVG_SEL = 2'd3;
    for (int i = 0; i < 5; i++) conv(8'h80);
    EN = 1'b0;
    tick();
    EN = 1'b1;
    for (int i = 0; i < 7; i++) conv(8'hFF);
    chk("clr7_valid", DVALID, 0);
    conv(8'hFF);
    chk("clr8_level", LEVEL, 1);
    pop_chk("clr8", 8'hFF);
    chk("clr_empty", DVALID, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
